// File: rtl/modexp_result_drain.sv
// modexp_result_drain: drains modexp result memory after completion into 64-bit valid/ready beats
module modexp_result_drain #(
  parameter int RD_LATENCY = 1,
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        core_start,
  input  logic        core_ready,
  input  logic [7:0]  modulus_length,
  input  logic        abort,
  output logic        result_mem_api_cs,
  output logic        result_mem_api_rst,
  input  logic [31:0] result_mem_api_read_data,
  output logic [63:0] out_data,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);
  localparam int IW = $clog2(MAX_WORDS + 1);
  localparam int LW = $clog2(RD_LATENCY + 1);
  typedef enum logic [2:0] {IDLE, ARMED, PTR_RST, WAIT, CAPTURE, EMIT, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] len, idx;
  logic [LW-1:0] wcnt;
  logic [63:0] pair;
  logic ready_q;
  assign out_valid = state == EMIT;
  assign out_last = out_valid && idx == len;
  assign out_data = pair;
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    result_mem_api_cs = 1'b0;
    result_mem_api_rst = 1'b0;
    case (state)
      IDLE: state_n = core_start ? ARMED : IDLE;
      ARMED: if (core_ready && !ready_q) state_n = len == '0 ? DONE : PTR_RST;
      PTR_RST: begin
        result_mem_api_rst = 1'b1;
        state_n = WAIT;
      end
      WAIT: state_n = wcnt == LW'(RD_LATENCY - 1) ? CAPTURE : WAIT;
      CAPTURE: begin
        state_n = idx[0] || idx + 1'b1 == len ? EMIT : WAIT;
        result_mem_api_cs = !(idx[0] || idx + 1'b1 == len);
      end
      EMIT: if (out_ready) begin
        state_n = out_last ? DONE : WAIT;
        result_mem_api_cs = !out_last;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // abort wins over everything, including a same-cycle beat accept
    if (abort) begin
      state_n = IDLE;
      result_mem_api_cs = 1'b0;
      result_mem_api_rst = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      len <= '0;
      idx <= '0;
      wcnt <= '0;
      pair <= '0;
      ready_q <= 1'b0;
    end else begin
      state <= state_n;
      ready_q <= core_ready;
      wcnt <= state == WAIT && !abort ? wcnt + 1'b1 : '0;
      if (abort) begin
        len <= '0;
        idx <= '0;
        pair <= '0;
      end else if (state == IDLE && core_start) begin
        len <= IW'(modulus_length);
        idx <= '0;
        pair <= '0;
      end else if (state == CAPTURE) begin
        idx <= idx + 1'b1;
        if (idx[0]) pair[63:32] <= result_mem_api_read_data;
        else pair[31:0] <= result_mem_api_read_data;
      end else if (state == EMIT && out_ready) pair <= '0;
    end
endmodule

// File: tb/tb_modexp_result_drain.sv
// tb_modexp_result_drain: directed runs on RD_LATENCY=1 and RD_LATENCY=3 instances against a beat-queue model
module tb_modexp_result_drain;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic core_start = 1'b0, core_ready = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic [7:0] modulus_length = 8'd0;
  logic [31:0] rd0, rd1, p_a, p_b;
  logic [63:0] od [2];
  logic ol [2], ov [2], cs [2], rs [2], bz [2], dn [2];
  logic [31:0] mem [256];
  logic [7:0] ptr [2] = '{8'd0, 8'd0};
  int total = 0, bad = 0;
  logic [64:0] exp_beat [2][128];
  int head [2], tail [2], pend_done [2], exp_cs [2], exp_rst [2], cs_run [2], rs_run [2];
  logic hold [2], last_acc [2], first_pend [2];
  logic [63:0] hold_data [2], first_beat [2], last_beat [2];

  always #5 clk = ~clk;

  modexp_result_drain #(.RD_LATENCY(1)) u1 (
    .clk(clk), .reset_n(reset_n), .core_start(core_start), .core_ready(core_ready),
    .modulus_length(modulus_length), .abort(abort), .result_mem_api_cs(cs[0]),
    .result_mem_api_rst(rs[0]), .result_mem_api_read_data(rd0), .out_data(od[0]),
    .out_last(ol[0]), .out_valid(ov[0]), .out_ready(out_ready), .busy(bz[0]), .done(dn[0]));
  modexp_result_drain #(.RD_LATENCY(3)) u3 (
    .clk(clk), .reset_n(reset_n), .core_start(core_start), .core_ready(core_ready),
    .modulus_length(modulus_length), .abort(abort), .result_mem_api_cs(cs[1]),
    .result_mem_api_rst(rs[1]), .result_mem_api_read_data(rd1), .out_data(od[1]),
    .out_last(ol[1]), .out_valid(ov[1]), .out_ready(out_ready), .busy(bz[1]), .done(dn[1]));

  // result memory: pointer moves on the edge; u3 sees the word two extra registers later
  assign rd0 = mem[ptr[0]];
  assign rd1 = p_b;
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (rs[k]) ptr[k] <= 8'd0;
      else if (cs[k]) ptr[k] <= ptr[k] + 8'd1;
    p_a <= mem[ptr[1]];
    p_b <= p_a;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD0000 | 32'(i);
    for (int i = 0; i < n; i++) mem[i] = base + 32'(i);
  endtask

  task automatic arm(input int len);
    int nb;
    nb = (len + 1) / 2;
    for (int k = 0; k < 2; k++) begin
      head[k] = 0;
      tail[k] = nb;
      pend_done[k] = 1;
      exp_cs[k] = len == 0 ? 0 : len - 1;
      exp_rst[k] = len == 0 ? 0 : 1;
      cs_run[k] = 0;
      rs_run[k] = 0;
      first_pend[k] = 1'b1;
      for (int b = 0; b < nb; b++)
        exp_beat[k][b] = {b == nb - 1, (2 * b + 1 < len) ? mem[2 * b + 1] : 32'h0, mem[2 * b]};
    end
  endtask

  task automatic clear_model;
    for (int k = 0; k < 2; k++) begin
      head[k] = 0;
      tail[k] = 0;
      pend_done[k] = 0;
    end
  endtask

  task automatic start_run(input int len);
    modulus_length = 8'(len);
    arm(len);
    core_start = 1'b1;
    tick;
    core_start = 1'b0;
  endtask

  task automatic rise;
    core_ready = 1'b0;
    tick;
    core_ready = 1'b1;
    tick;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((pend_done[0] > 0 || pend_done[1] > 0) && n < budget) begin
      tick;
      n++;
    end
    chk("drain_complete", 64'(pend_done[0] + pend_done[1]), 64'd0);
    core_ready = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!ov[0] && n < budget) begin
      tick;
      n++;
    end
    chk("valid_seen", 64'(ov[0]), 64'd1);
  endtask

  task automatic check_quiet(input string nm);
    for (int k = 0; k < 2; k++)
      chk(nm, 64'(|od[k] | ol[k] | ov[k] | cs[k] | rs[k] | bz[k] | dn[k]), 64'd0);
  endtask

  // scoreboard: every cycle, both instances
  initial begin
    for (int k = 0; k < 2; k++) begin
      hold[k] = 1'b0;
      last_acc[k] = 1'b0;
      head[k] = 0;
      tail[k] = 0;
      pend_done[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        if (!reset_n) begin
          hold[k] = 1'b0;
          last_acc[k] = 1'b0;
        end else begin
          if (cs[k] | rs[k]) chk("cs_rst_excl", 64'(cs[k] & rs[k]), 64'd0);
          cs_run[k] += int'(cs[k]);
          rs_run[k] += int'(rs[k]);
          if (hold[k]) begin
            chk("stall_valid", 64'(ov[k]), 64'd1);
            chk("stall_data", od[k], hold_data[k]);
          end
          if (dn[k]) begin
            chk("done_expected", 64'(pend_done[k] > 0), 64'd1);
            chk("done_busy", 64'(bz[k]), 64'd0);
            if (pend_done[k] > 0) begin
              if (tail[k] > 0) chk("done_after_last", 64'(last_acc[k]), 64'd1);
              chk("cs_count", 64'(cs_run[k]), 64'(exp_cs[k]));
              chk("rst_count", 64'(rs_run[k]), 64'(exp_rst[k]));
              chk("done_drained", 64'(tail[k] - head[k]), 64'd0);
              pend_done[k]--;
            end
          end
          last_acc[k] = 1'b0;
          if (ov[k] && out_ready && !abort) begin
            chk("beat_expected", 64'(head[k] < tail[k]), 64'd1);
            if (head[k] < tail[k]) begin
              chk("beat_data", od[k], exp_beat[k][head[k]][63:0]);
              chk("beat_last", 64'(ol[k]), 64'(exp_beat[k][head[k]][64]));
              head[k]++;
            end
            last_acc[k] = ol[k];
            last_beat[k] = od[k];
            if (first_pend[k]) first_beat[k] = od[k];
            first_pend[k] = 1'b0;
          end
          hold[k] = ov[k] & !out_ready & !abort;
          hold_data[k] = od[k];
        end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    fill(32'h0, 0);
    #2 reset_n = 1'b0;
    #1 check_quiet("reset_outputs");
    repeat (3) tick;
    reset_n = 1'b1;
    tick;
    // len=4 straight drain
    fill(32'h000000A0, 4);
    start_run(4);
    rise;
    wait_done(200);
    chk("t1_first", first_beat[0], 64'h000000A1_000000A0);
    chk("t1_last", last_beat[0], 64'h000000A3_000000A2);
    chk("t1_first_l3", first_beat[1], 64'h000000A1_000000A0);
    chk("t1_cs", 64'(cs_run[0]), 64'd3);
    chk("t1_rst", 64'(rs_run[0]), 64'd1);
    // len=3 with a start pulse and core_ready drop mid-drain, both ignored
    fill(32'h0, 0);
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    start_run(3);
    rise;
    core_ready = 1'b0;
    modulus_length = 8'd1;
    core_start = 1'b1;
    tick;
    core_start = 1'b0;
    wait_done(200);
    chk("t2_first", first_beat[0], 64'h00000022_00000011);
    chk("t2_last", last_beat[0], 64'h00000000_00000033);
    chk("t2_cs", 64'(cs_run[0]), 64'd2);
    // len=4 with a 20-cycle stall on beat 0
    fill(32'h000000C0, 4);
    out_ready = 1'b0;
    start_run(4);
    rise;
    wait_valid(50);
    repeat (20) tick;
    chk("t3_no_extra_cs", 64'(cs_run[0]), 64'd1);
    out_ready = 1'b1;
    wait_done(200);
    chk("t3_last", last_beat[0], 64'h000000C3_000000C2);
    // len=0 with core_ready already high: needs a fresh rising edge
    core_ready = 1'b1;
    start_run(0);
    repeat (5) tick;
    chk("t4_no_level_trigger", 64'(pend_done[0]), 64'd1);
    chk("t4_busy_armed", 64'(bz[0]), 64'd1);
    core_ready = 1'b0;
    tick;
    core_ready = 1'b1;
    wait_done(50);
    // abort on beat 1 with a same-cycle accept
    fill(32'h000000D0, 4);
    out_ready = 1'b0;
    start_run(4);
    rise;
    wait_valid(50);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    wait_valid(50);
    abort = 1'b1;
    out_ready = 1'b1;
    clear_model;
    tick;
    abort = 1'b0;
    core_ready = 1'b0;
    check_quiet("t5_after_abort");
    repeat (10) tick;
    fill(32'h000000E0, 2);
    start_run(2);
    rise;
    wait_done(200);
    chk("t5_rerun", first_beat[0], 64'h000000E1_000000E0);
    chk("t5_rerun_l3", last_beat[1], 64'h000000E1_000000E0);
    // reset mid-WAIT, then a clean len=2 run through the latency-3 instance
    fill(32'h000000F0, 4);
    start_run(4);
    rise;
    tick;
    reset_n = 1'b0;
    #1 check_quiet("t6_async_reset");
    clear_model;
    core_ready = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
    repeat (5) tick;
    check_quiet("t6_after_release");
    fill(32'h000000B0, 2);
    start_run(2);
    rise;
    wait_done(200);
    chk("t6_l3_beat", first_beat[1], 64'h000000B1_000000B0);
    chk("t6_l3_cs", 64'(cs_run[1]), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
